// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-RAM write port of the program loader.
// master: byte source / RAM side; slave: the loader itself.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/prog_loader.sv
// Program loader: takes a length-prefixed byte stream, writes it into the
// instruction RAM, pads the rest with FILL_WORD and holds the CPU in reset
// until the image is complete.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing checksum byte
// (mod-256 sum of length and data bytes) that must match before release.
module prog_loader #(
  parameter int unsigned       DEPTH     = 16,
  parameter int unsigned       ADDR_W    = 4,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] FILL_WORD = 8'hF0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  prog_loader_if.slave   bus,
  output logic           cpu_reset_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           error_o
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLen  = 3'd1;
  localparam logic [2:0] StData = 3'd2;
  localparam logic [2:0] StFill = 3'd3;
  localparam logic [2:0] StRun  = 3'd4;
  localparam logic [2:0] StErr  = 3'd5;
  localparam logic [2:0] StCsum = 3'd6;

  localparam logic [DATA_W-1:0] DepthD = DATA_W'(DEPTH);
  localparam logic [ADDR_W:0]   DepthC = (ADDR_W + 1)'(DEPTH);

`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] StAfterLoad = StCsum;
`else
  localparam logic [2:0] StAfterLoad = StRun;
`endif

  logic [2:0]        state_q, state_d;
  // One bit wider than an address so it can sit at DEPTH once every
  // address has been written; only the low bits ever reach wr_addr.
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  assign accept = bus.in_valid & in_ready_q;

  // Next-state, counter and write-port decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      StIdle, StRun, StErr: begin
        if (start_i) begin
          state_d = StLen;
          cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StLen: begin
        if (accept) begin
          if (bus.in_data == '0 || bus.in_data > DepthD) begin
            state_d = StErr;
          end else begin
            len_d   = bus.in_data[ADDR_W:0];
            state_d = StData;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = sum_q + bus.in_data;
`endif
          end
        end
      end
      StData: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = bus.in_data;
          cnt_d     = cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d     = sum_q + bus.in_data;
`endif
          if ((cnt_q + 1'b1) == len_q) state_d = StFill;
        end
      end
      StFill: begin
        // A full-length load arrives here with cnt already at DEPTH and just
        // spends one cycle, so the last write lands before the CPU is freed.
        if (cnt_q == DepthC) begin
          state_d = StAfterLoad;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = FILL_WORD;
          cnt_d     = cnt_q + 1'b1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) state_d = (bus.in_data == sum_q) ? StRun : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are decoded from the next state so they register in step.
  always_comb begin
    in_ready_d  = (state_d == StLen) || (state_d == StData) || (state_d == StCsum);
    busy_d      = (state_d == StLen) || (state_d == StData) || (state_d == StFill) ||
                  (state_d == StCsum);
    done_d      = (state_d == StRun);
    error_d     = (state_d == StErr);
    cpu_reset_d = (state_d != StRun);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign cpu_reset_o  = cpu_reset_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

endmodule
